// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encoding and types for the universal shift register.
package univ_shift_reg_pkg;

  typedef logic [1:0] shreg_mode_t;

  localparam shreg_mode_t MODE_HOLD = 2'b00;
  localparam shreg_mode_t MODE_SHR  = 2'b01;
  localparam shreg_mode_t MODE_SHL  = 2'b10;
  localparam shreg_mode_t MODE_LOAD = 2'b11;

  function automatic logic is_shift(input shreg_mode_t m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register.
// Parity signals exist only when UNIV_SHIFT_REG_PARITY_EN is defined.
interface univ_shift_reg_if #(parameter int WIDTH = 4);
  import univ_shift_reg_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  logic             clr;
  logic             en;
  shreg_mode_t      mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    bit_cnt;
  logic             word_rdy;
`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic             par_in;
  logic             parity;
  logic             par_err;

  modport master (output clr, en, mode, d, sin_l, sin_r, par_in,
                  input  q, sout_r, sout_l, bit_cnt, word_rdy, parity, par_err);
  modport slave  (input  clr, en, mode, d, sin_l, sin_r, par_in,
                  output q, sout_r, sout_l, bit_cnt, word_rdy, parity, par_err);
`else
  modport master (output clr, en, mode, d, sin_l, sin_r,
                  input  q, sout_r, sout_l, bit_cnt, word_rdy);
  modport slave  (input  clr, en, mode, d, sin_l, sin_r,
                  output q, sout_r, sout_l, bit_cnt, word_rdy);
`endif

endinterface

// File: rtl/univ_shift_reg_cell.sv
// One storage bit of the shift register: hold / shift-right / shift-left / load mux.
import univ_shift_reg_pkg::*;

module shreg_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  shreg_mode_t mode,
  input  logic        hi,   // neighbour above, taken on shift right
  input  logic        lo,   // neighbour below, taken on shift left
  input  logic        d,
  output logic        q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= RST_BIT;
    else if (clr) q <= RST_BIT;
    else if (en) begin
      case (mode)
        MODE_SHR:  q <= hi;
        MODE_SHL:  q <= lo;
        MODE_LOAD: q <= d;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register (hold/shr/shl/load) with word counter.
// Define UNIV_SHIFT_REG_PARITY_EN to add parity, par_in and par_err.
import univ_shift_reg_pkg::*;

module univ_shift_reg #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  univ_shift_reg_if.slave       bus
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] hi_v;
  logic [WIDTH-1:0] lo_v;
  logic [CW-1:0]    bit_cnt;
  logic             word_rdy;

  assign hi_v = {bus.sin_l, q[WIDTH-1:1]};
  assign lo_v = {q[WIDTH-2:0], bus.sin_r};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shreg_cell #(.RST_BIT(RST_VAL[i])) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.clr),
      .en    (bus.en),
      .mode  (bus.mode),
      .hi    (hi_v[i]),
      .lo    (lo_v[i]),
      .d     (bus.d[i]),
      .q     (q[i])
    );
  end

  // Counter survives direction changes, holds and en=0; only load/clr/reset zero it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      word_rdy <= 1'b0;
    end else if (bus.clr) begin
      bit_cnt  <= '0;
      word_rdy <= 1'b0;
    end else begin
      word_rdy <= 1'b0;
      if (bus.en) begin
        if (bus.mode == MODE_LOAD) begin
          bit_cnt <= '0;
        end else if (is_shift(bus.mode)) begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt  <= '0;
            word_rdy <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      end
    end
  end

  assign bus.q        = q;
  assign bus.sout_r   = q[0];
  assign bus.sout_l   = q[WIDTH-1];
  assign bus.bit_cnt  = bit_cnt;
  assign bus.word_rdy = word_rdy;

`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic par_err;

  // Sticky: a bad load flags until clr or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       par_err <= 1'b0;
    else if (bus.clr) par_err <= 1'b0;
    else if (bus.en && bus.mode == MODE_LOAD && ((^bus.d) != bus.par_in))
      par_err <= 1'b1;
  end

  assign bus.parity  = ^q;
  assign bus.par_err = par_err;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Table-driven bench for univ_shift_reg (WIDTH=4) with an expected-value queue.
`timescale 1ns/1ps
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(4)) bus();

  univ_shift_reg #(.WIDTH(4), .RST_VAL(4'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        clr;
    logic        en;
    shreg_mode_t mode;
    logic [3:0]  d;
    logic        sl;
    logic        sr;
    logic [3:0]  q;
    logic [2:0]  cnt;
    logic        rdy;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic [2:0] cnt;
    logic       rdy;
    int         id;
  } exp_t;

  vec_t tbl[28];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic compare_next();
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: empty queue at sample point");
      return;
    end
    e = sb.pop_front();
    chk("q",        e.id, 64'(bus.q),        64'(e.q));
    chk("bit_cnt",  e.id, 64'(bus.bit_cnt),  64'(e.cnt));
    chk("word_rdy", e.id, 64'(bus.word_rdy), 64'(e.rdy));
    chk("sout_r",   e.id, 64'(bus.sout_r),   64'(e.q[0]));
    chk("sout_l",   e.id, 64'(bus.sout_l),   64'(e.q[3]));
  endtask

  // Drive one cycle of inputs, push the expectation, sample after the edge.
  task automatic drive(input vec_t v, input int id);
    bus.clr   = v.clr;
    bus.en    = v.en;
    bus.mode  = v.mode;
    bus.d     = v.d;
    bus.sin_l = v.sl;
    bus.sin_r = v.sr;
    sb.push_back('{q: v.q, cnt: v.cnt, rdy: v.rdy, id: id});
    @(posedge clk); #1;
    compare_next();
  endtask

  function automatic vec_t mk(logic c, logic e, shreg_mode_t m, logic [3:0] dd,
                              logic sl, logic sr, logic [3:0] eq, logic [2:0] ec, logic er);
    vec_t v;
    v.clr = c; v.en = e; v.mode = m; v.d = dd; v.sl = sl; v.sr = sr;
    v.q = eq; v.cnt = ec; v.rdy = er;
    return v;
  endfunction

  initial begin
    //             clr en mode       d     sl sr   q     cnt rdy
    tbl[0]  = mk(0, 1, MODE_LOAD, 4'hB, 0, 0, 4'hB, 0, 0); // PIPO load
    tbl[1]  = mk(0, 1, MODE_HOLD, 4'h0, 1, 1, 4'hB, 0, 0);
    tbl[2]  = mk(0, 1, MODE_HOLD, 4'h5, 0, 1, 4'hB, 0, 0);
    tbl[3]  = mk(0, 1, MODE_HOLD, 4'hF, 1, 0, 4'hB, 0, 0);
    tbl[4]  = mk(1, 1, MODE_LOAD, 4'hF, 0, 0, 4'h0, 0, 0); // clr beats load
    tbl[5]  = mk(0, 1, MODE_SHR,  4'h0, 1, 0, 4'h8, 1, 0); // SIPO right 1,0,1,1
    tbl[6]  = mk(0, 1, MODE_SHR,  4'h0, 0, 0, 4'h4, 2, 0);
    tbl[7]  = mk(0, 1, MODE_SHR,  4'h0, 1, 0, 4'hA, 3, 0);
    tbl[8]  = mk(0, 1, MODE_SHR,  4'h0, 1, 0, 4'hD, 0, 1);
    tbl[9]  = mk(0, 1, MODE_HOLD, 4'h0, 0, 0, 4'hD, 0, 0);
    tbl[10] = mk(0, 1, MODE_LOAD, 4'h9, 0, 0, 4'h9, 0, 0); // PISO left
    tbl[11] = mk(0, 1, MODE_SHL,  4'h0, 0, 0, 4'h2, 1, 0);
    tbl[12] = mk(0, 1, MODE_SHL,  4'h0, 0, 0, 4'h4, 2, 0);
    tbl[13] = mk(0, 1, MODE_SHL,  4'h0, 0, 0, 4'h8, 3, 0);
    tbl[14] = mk(0, 1, MODE_SHL,  4'h0, 0, 0, 4'h0, 0, 1);
    tbl[15] = mk(0, 1, MODE_LOAD, 4'h5, 0, 0, 4'h5, 0, 0); // enable/priority
    tbl[16] = mk(0, 1, MODE_SHL,  4'h0, 0, 1, 4'hB, 1, 0);
    tbl[17] = mk(0, 1, MODE_SHR,  4'h0, 0, 1, 4'h5, 2, 0); // direction change keeps count
    tbl[18] = mk(0, 0, MODE_SHL,  4'h0, 1, 1, 4'h5, 2, 0);
    tbl[19] = mk(0, 0, MODE_LOAD, 4'hE, 1, 1, 4'h5, 2, 0);
    tbl[20] = mk(1, 0, MODE_SHL,  4'h0, 1, 1, 4'h0, 0, 0); // clr with en=0
    tbl[21] = mk(0, 1, MODE_SHR,  4'h0, 1, 0, 4'h8, 1, 0); // stretched word
    tbl[22] = mk(0, 1, MODE_HOLD, 4'h0, 0, 0, 4'h8, 1, 0);
    tbl[23] = mk(0, 1, MODE_SHR,  4'h0, 1, 0, 4'hC, 2, 0);
    tbl[24] = mk(0, 0, MODE_SHR,  4'h0, 0, 0, 4'hC, 2, 0);
    tbl[25] = mk(0, 1, MODE_SHR,  4'h0, 0, 0, 4'h6, 3, 0);
    tbl[26] = mk(0, 1, MODE_SHR,  4'h0, 1, 0, 4'hB, 0, 1);
    tbl[27] = mk(0, 1, MODE_SHR,  4'h0, 1, 0, 4'hD, 1, 0);

    bus.clr = 0; bus.en = 0; bus.mode = MODE_HOLD; bus.d = '0;
    bus.sin_l = 0; bus.sin_r = 0;
`ifdef UNIV_SHIFT_REG_PARITY_EN
    bus.par_in = 0;
`endif

    // Reset state while rst_n held low
    repeat (2) @(posedge clk);
    #1;
    chk("rst q",   0, 64'(bus.q),        64'h0);
    chk("rst cnt", 0, 64'(bus.bit_cnt),  64'h0);
    chk("rst rdy", 0, 64'(bus.word_rdy), 64'h0);
    rst_n = 1;

    // Async reset mid-word: load A, shift once, then drop rst_n between edges
    drive(mk(0, 1, MODE_LOAD, 4'hA, 0, 0, 4'hA, 0, 0), 100);
    drive(mk(0, 1, MODE_SHR,  4'h0, 0, 0, 4'h5, 1, 0), 101);
    #3 rst_n = 0;
    #1;
    chk("async q",   102, 64'(bus.q),        64'h0);
    chk("async cnt", 102, 64'(bus.bit_cnt),  64'h0);
    chk("async rdy", 102, 64'(bus.word_rdy), 64'h0);
    bus.en = 1; bus.mode = MODE_LOAD; bus.d = 4'hF;
    @(posedge clk); #1;
    chk("held q",   103, 64'(bus.q),       64'h0);
    chk("held cnt", 103, 64'(bus.bit_cnt), 64'h0);
    rst_n = 1;
    bus.mode = MODE_HOLD;

    for (int i = 0; i < 28; i++) drive(tbl[i], i);

`ifdef UNIV_SHIFT_REG_PARITY_EN
    bus.par_in = 0;
    drive(mk(0, 1, MODE_LOAD, 4'h7, 0, 0, 4'h7, 0, 0), 200);
    chk("parity",  200, 64'(bus.parity),  64'h1);
    chk("par_err", 200, 64'(bus.par_err), 64'h1);
    drive(mk(0, 1, MODE_HOLD, 4'h0, 0, 0, 4'h7, 0, 0), 201);
    chk("par_err sticky", 201, 64'(bus.par_err), 64'h1);
    drive(mk(1, 1, MODE_HOLD, 4'h0, 0, 0, 4'h0, 0, 0), 202);
    chk("par_err clr", 202, 64'(bus.par_err), 64'h0);
    drive(mk(0, 1, MODE_LOAD, 4'h3, 0, 0, 4'h3, 0, 0), 203);
    chk("parity even", 203, 64'(bus.parity),  64'h0);
    chk("par_err ok",  203, 64'(bus.par_err), 64'h0);
`endif

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
